lcd_rx_monitor: RTL
===================

# lcd_rx_monitor

Receive-side counterpart of the LCD timing generator: samples a parallel RGB555 LCD stream (DE, HSYNC, VSYNC, 5/5/5 colour), measures its horizontal/vertical timing, declares lock once timing is stable, and re-emits active pixels with X/Y coordinates. It sits behind the generator in loopback benches and in front of capture/scaler logic in designs that consume an external LCD-style video source.

## Interface
- `SYNC_ACTIVE_LOW`, 1, HSYNC/VSYNC asserted level is 0 when 1, 1 when 0.
- `CNT_W`, 12, width of all pixel/line counters and measurement outputs.
- `LOCK_FRAMES`, 2, number of consecutive identical frame measurements required for lock (1..15).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `pixel_en`  in  1  pixel strobe; inputs are sampled and counters advance only when 1.
- `lcd_de`  in  1  data enable.
- `lcd_hsync`  in  1  horizontal sync (polarity per `SYNC_ACTIVE_LOW`).
- `lcd_vsync`  in  1  vertical sync.
- `lcd_red`, `lcd_green`, `lcd_blue`  in  5 each  pixel colour.
- `pix_valid`  out  1  one-cycle pulse per active pixel.
- `pix_x`, `pix_y`  out  `CNT_W`  active-area coordinates of the pixel.
- `pix_rgb`  out  15  {red, green, blue}.
- `frame_start`  out  1  one-cycle pulse on VSYNC assertion.
- `h_total`, `h_active`, `v_total`, `v_active`  out  `CNT_W`  latest measurements.
- `locked`  out  1  timing stable.
- `err_timing`  out  1  one-cycle pulse on measurement mismatch while locked.
- `err_overflow`  out  1  sticky; set when any counter saturates, cleared only by reset.

## Operation
- Stage 1: when `pixel_en`=1, register DE, polarity-normalised HS/VS, RGB; keep previous HS/VS for edge detection. Assertion edge = normalised 0→1.
- `hcnt`: +1 per strobe; on HS assertion, latch `h_total` ← hcnt+1, reset hcnt to 0.
- `de_cnt`: +1 per strobe with DE=1; on DE 1→0 latch `h_active` ← de_cnt, clear de_cnt.
- `vcnt`: +1 on each HS assertion; on VS assertion latch `v_total` ← vcnt, clear vcnt. HS and VS asserting on the same strobe: hcnt handling first, vcnt cleared (not incremented).
- `line_act`: set when DE seen in current line; at HS assertion, if set, `act_lines`+1. On VS assertion latch `v_active` ← act_lines, clear.
- Pixel path: `pix_x` = de_cnt before increment, `pix_y` = act_lines; DE 1→0 mid-line resets pix_x to 0 for next run.
- Lock FSM states: UNLOCKED, ACQUIRE, LOCKED. UNLOCKED→ACQUIRE at first VS assertion (stores snapshot). In ACQUIRE, each VS compares all four measurements with snapshot: equal → match_cnt+1, reaching `LOCK_FRAMES` → LOCKED; unequal → snapshot replaced, match_cnt=1. In LOCKED, mismatch → pulse `err_timing`, go ACQUIRE with new snapshot, `locked`=0.
- Saturation: any counter at 2^`CNT_W`-1 holds and sets `err_overflow`.
- `pixel_en`=0 freezes all state; pulses are not generated.

## Timing
- Reset values: all outputs 0, FSM UNLOCKED, counters 0, previous HS/VS = 0 (deasserted).
- Pixel latency: input sampled at strobe edge N → `pix_valid`/`pix_x`/`pix_y`/`pix_rgb` valid at edge N+1 (2 register stages incl. input).
- `frame_start`, measurement updates, `locked`, `err_timing`: same latency as pixel path, relative to the strobe carrying the sync edge.
- Measurement latch and lock decision on the same edge use the newly latched values.
- Reset mid-frame: everything returns to reset state immediately; first `h_total` after reset is invalid (partial line), lock cannot occur before `LOCK_FRAMES`+1 VS edges.

## Structure
- Package `lcd_pkg`: `CNT_W` default, RGB555 width constant, lock-state enum, shared with the timing generator.
- One sub-module `lcd_sync_edge` (polarity normalise + register + assertion-edge pulse), instantiated for HS, VS and DE falling edge.

## Test plan
- Synthetic timing 16 clk/line, DE 10, HS width 2, 8 lines/frame, 5 active, `pixel_en`=1 → after 3 frames `h_total`=16, `h_active`=10, `v_total`=8, `v_active`=5, `locked`=1.
- Same stream: 50 `pix_valid` pulses per frame; first pixel x=0,y=0, last x=9,y=4, pix_rgb matches input.
- After lock, change line length to 18 → `err_timing` one pulse, `locked`=0, relocks after 2 stable frames.
- `pixel_en` toggled every other clk with same timing → identical measurements; no pulses in `pixel_en`=0 cycles.
- `SYNC_ACTIVE_LOW`=0 with inverted sync → same results as scenario 1.
- HS held deasserted 5000 clk (`CNT_W`=12) → hcnt saturates at 4095, `err_overflow`=1 until `reset` asserted mid-frame, then all outputs 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared LCD video definitions for the RGB555 timing generator and receive monitor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package lcd_pkg;

  // Default width of pixel/line counters and timing measurements.
  localparam int CNT_W_DEF = 12;

  // RGB555 pixel format.
  localparam int COLOR_W = 5;
  localparam int RGB_W   = 3 * COLOR_W;

  // Width of the consecutive-match counter used by lock detection (lock depth 1..15).
  localparam int MATCH_W = 4;

  // Timing-lock state machine.
  typedef enum logic [1:0] {
    LOCK_UNLOCKED = 2'd0,
    LOCK_ACQUIRE  = 2'd1,
    LOCK_LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/lcd_sync_edge.sv
// Polarity-normalising sync register with assertion-edge detect.
// Latency: level registered on a strobe edge; edge pulse valid until the next strobe.
// Backpressure: none; holds state while en is low.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   en         : pixel strobe; sig is sampled only when en=1
//   sig        : raw sync/enable input
//   rise       : normalised level went 0->1 between the last two strobes
//
// INVERT=1 turns an active-low input into an active-high normalised level.
// RST_VAL is the normalised level held in reset, chosen so that the idle
// input level does not fake an assertion on the first strobe after reset.
module lcd_sync_edge #(
  parameter bit INVERT  = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sig,
  output logic rise
);

  logic lvl;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl  <= RST_VAL;
      prev <= RST_VAL;
    end else if (en) begin
      prev <= lvl;
      lvl  <= sig ^ INVERT;
    end
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/lcd_rx_monitor.sv
// Receive-side LCD monitor: measures H/V timing, detects lock, re-emits active pixels with X/Y.
// Latency: input sampled on strobe edge N appears on outputs at strobe edge N+1.
// Backpressure: none; pixel_en=0 freezes all state and suppresses every pulse output.
//
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   pixel_en                       : pixel strobe qualifying every input sample
//   lcd_de/hsync/vsync/red/green/blue : incoming LCD stream (sync polarity by SYNC_ACTIVE_LOW)
//   pix_valid, pix_x, pix_y, pix_rgb  : one pulse per active pixel with its coordinates
//   frame_start                    : pulse on VSYNC assertion
//   h_total, h_active, v_total, v_active : latest timing measurements
//   locked, err_timing, err_overflow     : lock status, mismatch pulse, sticky saturation flag
module lcd_rx_monitor
  import lcd_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_en,
  input  logic               lcd_de,
  input  logic               lcd_hsync,
  input  logic               lcd_vsync,
  input  logic [COLOR_W-1:0] lcd_red,
  input  logic [COLOR_W-1:0] lcd_green,
  input  logic [COLOR_W-1:0] lcd_blue,
  output logic               pix_valid,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic [RGB_W-1:0]   pix_rgb,
  output logic               frame_start,
  output logic [CNT_W-1:0]   h_total,
  output logic [CNT_W-1:0]   h_active,
  output logic [CNT_W-1:0]   v_total,
  output logic [CNT_W-1:0]   v_active,
  output logic               locked,
  output logic               err_timing,
  output logic               err_overflow
);

  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------
  // Stage 1: input registers and edge detection
  // ---------------------------------------------------------------
  logic             s1_de;
  logic [RGB_W-1:0] s1_rgb;
  logic             hs_rise;
  logic             vs_rise;
  logic             de_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_de  <= 1'b0;
      s1_rgb <= '0;
    end else if (pixel_en) begin
      s1_de  <= lcd_de;
      s1_rgb <= {lcd_red, lcd_green, lcd_blue};
    end
  end

  lcd_sync_edge #(
    .INVERT  (SYNC_ACTIVE_LOW),
    .RST_VAL (1'b0)
  ) u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_en),
    .sig   (lcd_hsync),
    .rise  (hs_rise)
  );

  lcd_sync_edge #(
    .INVERT  (SYNC_ACTIVE_LOW),
    .RST_VAL (1'b0)
  ) u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_en),
    .sig   (lcd_vsync),
    .rise  (vs_rise)
  );

  // DE is inverted so the "assertion" edge is DE falling; resetting the
  // normalised level to 1 means an idle DE=0 does not look like a fall.
  lcd_sync_edge #(
    .INVERT  (1'b1),
    .RST_VAL (1'b1)
  ) u_de_edge (
    .clk   (clk),
    .reset (reset),
    .en    (pixel_en),
    .sig   (lcd_de),
    .rise  (de_fall)
  );

  // ---------------------------------------------------------------
  // Stage 2: counters and measurements (next-state logic)
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] hcnt, de_cnt, vcnt, act_lines;
  logic             line_act;

  logic [CNT_W-1:0] hcnt_nx, de_cnt_nx, vcnt_nx, act_lines_nx;
  logic             line_act_nx;
  logic [CNT_W-1:0] h_total_nx, h_active_nx, v_total_nx, v_active_nx;
  logic             sat_hit;

  always_comb begin
    hcnt_nx      = hcnt;
    de_cnt_nx    = de_cnt;
    vcnt_nx      = vcnt;
    act_lines_nx = act_lines;
    line_act_nx  = line_act | s1_de;
    h_total_nx   = h_total;
    h_active_nx  = h_active;
    v_total_nx   = v_total;
    v_active_nx  = v_active;

    // Horizontal sync closes the line: the strobe carrying HS counts as
    // position 0 of the new line, hence total = hcnt + 1.
    if (hs_rise) begin
      h_total_nx  = sat_inc(hcnt);
      hcnt_nx     = '0;
      vcnt_nx     = sat_inc(vcnt);
      if (line_act) begin
        act_lines_nx = sat_inc(act_lines);
      end
      line_act_nx = s1_de;
    end else begin
      hcnt_nx = sat_inc(hcnt);
    end

    if (de_fall) begin
      h_active_nx = de_cnt;
      de_cnt_nx   = '0;
    end else if (s1_de) begin
      de_cnt_nx = sat_inc(de_cnt);
    end

    // Vertical sync uses the line counts after any coincident HS has been
    // applied, so a VS aligned with HS still counts that final line.
    if (vs_rise) begin
      v_total_nx   = vcnt_nx;
      v_active_nx  = act_lines_nx;
      vcnt_nx      = '0;
      act_lines_nx = '0;
    end
  end

  assign sat_hit = (hcnt_nx == CNT_MAX) || (de_cnt_nx == CNT_MAX) ||
                   (vcnt_nx == CNT_MAX) || (act_lines_nx == CNT_MAX);

  // ---------------------------------------------------------------
  // Stage 2: counter, measurement and pixel output registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt         <= '0;
      de_cnt       <= '0;
      vcnt         <= '0;
      act_lines    <= '0;
      line_act     <= 1'b0;
      h_total      <= '0;
      h_active     <= '0;
      v_total      <= '0;
      v_active     <= '0;
      err_overflow <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_rgb      <= '0;
      frame_start  <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (pixel_en) begin
        hcnt         <= hcnt_nx;
        de_cnt       <= de_cnt_nx;
        vcnt         <= vcnt_nx;
        act_lines    <= act_lines_nx;
        line_act     <= line_act_nx;
        h_total      <= h_total_nx;
        h_active     <= h_active_nx;
        v_total      <= v_total_nx;
        v_active     <= v_active_nx;
        err_overflow <= err_overflow | sat_hit;
        pix_valid    <= s1_de;
        frame_start  <= vs_rise;
        // Coordinates are the counts before this pixel is added.
        if (s1_de) begin
          pix_x   <= de_cnt;
          pix_y   <= act_lines;
          pix_rgb <= s1_rgb;
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Lock state machine, evaluated on VS against freshly latched values
  // ---------------------------------------------------------------
  lock_state_t        state;
  logic [MATCH_W-1:0] match_cnt;
  logic [MATCH_W-1:0] match_inc;
  logic [4*CNT_W-1:0] snap;
  logic [4*CNT_W-1:0] meas_nx;
  logic               meas_eq;

  assign meas_nx   = {h_total_nx, h_active_nx, v_total_nx, v_active_nx};
  assign meas_eq   = (meas_nx == snap);
  assign match_inc = match_cnt + MATCH_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOCK_UNLOCKED;
      match_cnt  <= '0;
      snap       <= '0;
      locked     <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      err_timing <= 1'b0;
      if (pixel_en && vs_rise) begin
        case (state)
          // The first snapshot after reset spans a partial frame, so it
          // does not count as a match; lock needs LOCK_FRAMES more VS edges.
          LOCK_UNLOCKED: begin
            snap      <= meas_nx;
            match_cnt <= '0;
            state     <= LOCK_ACQUIRE;
          end
          LOCK_ACQUIRE: begin
            if (meas_eq) begin
              match_cnt <= match_inc;
              if (match_inc >= LOCK_N) begin
                state  <= LOCK_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              snap      <= meas_nx;
              match_cnt <= MATCH_W'(1);
            end
          end
          LOCK_LOCKED: begin
            if (!meas_eq) begin
              err_timing <= 1'b1;
              locked     <= 1'b0;
              state      <= LOCK_ACQUIRE;
              snap       <= meas_nx;
              match_cnt  <= MATCH_W'(1);
            end
          end
          default: begin
            state  <= LOCK_UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
